// File: rtl/point_scan_if.sv
// Point-scan bus: host-side controls and the plotter handshake.
// The controller uses the master view and the host/plotter side uses the slave view.
interface point_scan_if;
   logic       start;
   logic       abort;
   logic       plot_ready;
   logic [3:0] x;
   logic [3:0] y;
   logic       plot_valid;
   logic       busy;
   logic       done;

   modport master (
      input  start, abort, plot_ready,
      output x, y, plot_valid, busy, done
   );

   modport slave (
      output start, abort, plot_ready,
      input  x, y, plot_valid, busy, done
   );
endinterface

// File: rtl/point_scan_ctrl.sv
// Raster-scan sequencer: walks (x,y) over the grid, X fastest, offering each point
// to the plotter over valid/ready, with optional idle gaps and a done pulse at the end.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; coordinates parked at (0,0)
//   S_ISSUE | current point offered, held until the plotter takes it
//   S_GAP   | idle cycles after an accepted point, counted down
//   S_DONE  | one-cycle completion pulse after the final point
module point_scan_ctrl #(
   parameter int X_MAX = 15,
   parameter int Y_MAX = 15,
   parameter int GAP   = 0
) (
   input  logic         clk,
   input  logic         resetn,
   point_scan_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] X_LAST   = 4'(X_MAX);
   localparam logic [3:0] Y_LAST   = 4'(Y_MAX);
   localparam logic       HAS_GAP  = (GAP > 0);
   // The gap counter runs down to zero, so it is loaded one short of the gap length.
   localparam logic [7:0] GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] x_q;
   logic [3:0] x_nxt;
   logic [3:0] y_q;
   logic [3:0] y_nxt;
   logic [7:0] gap_cnt;
   logic [7:0] gap_cnt_nxt;
   logic       valid_q;
   logic       busy_q;
   logic       done_q;

   always_comb begin
      state_nxt   = state;
      x_nxt       = x_q;
      y_nxt       = y_q;
      gap_cnt_nxt = gap_cnt;
      if (bus.abort) begin
         state_nxt   = S_IDLE;
         x_nxt       = 4'd0;
         y_nxt       = 4'd0;
         gap_cnt_nxt = 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               x_nxt = 4'd0;
               y_nxt = 4'd0;
               if (bus.start) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
               if (bus.plot_ready) begin
                  if (x_q == X_LAST && y_q == Y_LAST) begin
                     x_nxt     = 4'd0;
                     y_nxt     = 4'd0;
                     state_nxt = S_DONE;
                  end else begin
                     if (x_q == X_LAST) begin
                        x_nxt = 4'd0;
                        y_nxt = y_q + 4'd1;
                     end else begin
                        x_nxt = x_q + 4'd1;
                     end
                     if (HAS_GAP) begin
                        state_nxt   = S_GAP;
                        gap_cnt_nxt = GAP_LOAD;
                     end else begin
                        state_nxt = S_ISSUE;
                     end
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == 8'd0) state_nxt = S_ISSUE;
               else                 gap_cnt_nxt = gap_cnt - 8'd1;
            end
            S_DONE: begin
               state_nxt = S_IDLE;
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Status outputs are decoded from the next state so they line up with it after the edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= S_IDLE;
         x_q     <= 4'd0;
         y_q     <= 4'd0;
         gap_cnt <= 8'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         x_q     <= x_nxt;
         y_q     <= y_nxt;
         gap_cnt <= gap_cnt_nxt;
         valid_q <= (state_nxt == S_ISSUE);
         busy_q  <= (state_nxt == S_ISSUE) || (state_nxt == S_GAP);
         done_q  <= (state_nxt == S_DONE);
      end
   end

   assign bus.x          = x_q;
   assign bus.y          = y_q;
   assign bus.plot_valid = valid_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_point_scan_ctrl.sv
// Bench for point_scan_ctrl: a default 16x16 instance and a 4x2 instance with GAP=2,
// both driven by the same stimulus and checked cycle by cycle against a point-count model.
module tb_point_scan_ctrl;

   logic clk;
   logic resetn;
   logic start;
   logic abort;
   logic plot_ready;

   point_scan_if ifa ();
   point_scan_if ifb ();

   assign ifa.start      = start;
   assign ifa.abort      = abort;
   assign ifa.plot_ready = plot_ready;
   assign ifb.start      = start;
   assign ifb.abort      = abort;
   assign ifb.plot_ready = plot_ready;

   point_scan_ctrl u_a (.clk(clk), .resetn(resetn), .bus(ifa));
   point_scan_ctrl #(.X_MAX(3), .Y_MAX(1), .GAP(2)) u_b (.clk(clk), .resetn(resetn), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: per instance, whether a scan runs, how many points were accepted,
   // how many gap cycles remain, and whether the done pulse is due.
   int xm [2] = '{15, 3};
   int ym [2] = '{15, 1};
   int gp [2] = '{0, 2};
   int m_run  [2] = '{0, 0};
   int m_n    [2] = '{0, 0};
   int m_wait [2] = '{0, 0};
   int m_done [2] = '{0, 0};

   logic [7:0] qa [$];
   logic [7:0] qb [$];
   int         ca [$];

   function automatic logic [7:0] pt(int k, int d);
      logic [3:0] px;
      logic [3:0] py;
      px = 4'(k % (xm[d] + 1));
      py = 4'(k / (xm[d] + 1));
      return {px, py};
   endfunction

   task automatic step();
      logic [3:0] ox [2];
      logic [3:0] oy [2];
      logic       ov [2];
      logic       ob [2];
      logic       od [2];
      int         npts, ex, ey, ev;
      if (resetn && !abort) begin
         if (ifa.plot_valid && plot_ready) begin
            qa.push_back({ifa.x, ifa.y});
            ca.push_back(cyc + 1);
         end
         if (ifb.plot_valid && plot_ready) qb.push_back({ifb.x, ifb.y});
      end
      for (int d = 0; d < 2; d++) begin
         npts = (xm[d] + 1) * (ym[d] + 1);
         if (!resetn || abort) begin
            m_run[d] = 0; m_n[d] = 0; m_wait[d] = 0; m_done[d] = 0;
         end else if (m_run[d] != 0) begin
            m_done[d] = 0;
            if (m_wait[d] > 0) m_wait[d]--;
            else if (plot_ready) begin
               m_n[d]++;
               if (m_n[d] == npts) begin
                  m_run[d] = 0; m_n[d] = 0; m_done[d] = 1;
               end else m_wait[d] = gp[d];
            end
         end else begin
            if (m_done[d] == 0 && start) begin
               m_run[d] = 1; m_n[d] = 0; m_wait[d] = 0;
            end
            m_done[d] = 0;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      ox[0] = ifa.x; oy[0] = ifa.y; ov[0] = ifa.plot_valid; ob[0] = ifa.busy; od[0] = ifa.done;
      ox[1] = ifb.x; oy[1] = ifb.y; ov[1] = ifb.plot_valid; ob[1] = ifb.busy; od[1] = ifb.done;
      for (int d = 0; d < 2; d++) begin
         ex = (m_run[d] != 0) ? m_n[d] % (xm[d] + 1) : 0;
         ey = (m_run[d] != 0) ? m_n[d] / (xm[d] + 1) : 0;
         ev = (m_run[d] != 0 && m_wait[d] == 0) ? 1 : 0;
         total += 5;
         if (ox[d] !== 4'(ex)) begin bad++; $display("FAIL x dut%0d cyc=%0d got=%0d exp=%0d", d, cyc, ox[d], ex); end
         if (oy[d] !== 4'(ey)) begin bad++; $display("FAIL y dut%0d cyc=%0d got=%0d exp=%0d", d, cyc, oy[d], ey); end
         if (ov[d] !== 1'(ev)) begin bad++; $display("FAIL plot_valid dut%0d cyc=%0d got=%0b exp=%0d", d, cyc, ov[d], ev); end
         if (ob[d] !== 1'(m_run[d])) begin bad++; $display("FAIL busy dut%0d cyc=%0d got=%0b exp=%0d", d, cyc, ob[d], m_run[d]); end
         if (od[d] !== 1'(m_done[d])) begin bad++; $display("FAIL done dut%0d cyc=%0d got=%0b exp=%0d", d, cyc, od[d], m_done[d]); end
      end
   endtask

   task automatic clear();
      start = 1'b0; abort = 1'b1;
      step();
      abort = 1'b0;
      qa.delete(); qb.delete(); ca.delete();
   endtask

   task automatic test_reset();
      int bud;
      start = 1'b0; abort = 1'b0; plot_ready = 1'b0;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      #2;
      total++;
      if ({ifa.x, ifa.y, ifa.plot_valid, ifa.busy, ifa.done} !== 11'd0) begin
         bad++; $display("FAIL por_outputs got=%0h exp=0", {ifa.x, ifa.y, ifa.plot_valid, ifa.busy, ifa.done});
      end
      step(); step();
      resetn = 1'b1;
      step();
      plot_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      bud = 200;
      while (!(ifa.plot_valid && ifa.x == 4'd6 && ifa.y == 4'd3) && bud > 0) begin step(); bud--; end
      total++;
      if (bud == 0) begin bad++; $display("FAIL reach_6_3 got=timeout exp=point(6,3)"); end
      #2 resetn = 1'b0;
      #1;
      total++;
      if ({ifa.x, ifa.y, ifa.plot_valid, ifa.busy, ifa.done} !== 11'd0) begin
         bad++; $display("FAIL async_reset got=%0h exp=0", {ifa.x, ifa.y, ifa.plot_valid, ifa.busy, ifa.done});
      end
      step();
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if ({ifa.x, ifa.y, ifa.plot_valid, ifa.busy, ifa.done} !== 11'd0) begin
            bad++; $display("FAIL reset_idle got=%0h exp=0", {ifa.x, ifa.y, ifa.plot_valid, ifa.busy, ifa.done});
         end
      end
   endtask

   task automatic test_full_scan();
      int bud, ks, seq_ok, con_ok;
      clear();
      plot_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      ks = cyc;
      bud = 400;
      while (!ifa.done && bud > 0) begin step(); bud--; end
      total++;
      if (bud == 0) begin bad++; $display("FAIL full_done got=timeout exp=done"); end
      total++;
      if (qa.size() !== 256) begin bad++; $display("FAIL full_count got=%0d exp=256", qa.size()); end
      seq_ok = 1; con_ok = 1;
      foreach (qa[k]) if (qa[k] !== pt(k, 0)) seq_ok = 0;
      foreach (ca[k]) if (ca[k] !== ca[0] + k) con_ok = 0;
      total += 3;
      if (seq_ok != 1) begin bad++; $display("FAIL full_order got=out_of_order exp=raster_order"); end
      if (con_ok != 1) begin bad++; $display("FAIL full_consecutive got=gaps exp=one_per_cycle"); end
      if (ca.size() > 0 && ca[0] !== ks + 1) begin bad++; $display("FAIL first_xfer got=%0d exp=%0d", ca[0], ks + 1); end
      total += 2;
      if (ca.size() > 0 && ca[$] !== cyc) begin bad++; $display("FAIL done_timing got=%0d exp=%0d", cyc, ca[$]); end
      if (ifa.busy !== 1'b0) begin bad++; $display("FAIL busy_at_done got=%0b exp=0", ifa.busy); end
      step();
   endtask

   task automatic test_backpressure();
      int bud, seq_ok;
      clear();
      plot_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      bud = 100;
      while (!(ifa.plot_valid && ifa.x == 4'd5 && ifa.y == 4'd2) && bud > 0) begin step(); bud--; end
      total++;
      if (bud == 0) begin bad++; $display("FAIL reach_5_2 got=timeout exp=point(5,2)"); end
      plot_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if ({ifa.plot_valid, ifa.x, ifa.y} !== {1'b1, 4'd5, 4'd2}) begin
            bad++; $display("FAIL hold got=%0h exp=152", {ifa.plot_valid, ifa.x, ifa.y});
         end
      end
      plot_ready = 1'b1;
      step();
      total += 2;
      if (qa.size() == 0 || qa[$] !== 8'h52) begin bad++; $display("FAIL bp_accept got=%0d_pts exp=last_(5,2)", qa.size()); end
      if ({ifa.x, ifa.y} !== 8'h62) begin bad++; $display("FAIL bp_next got=%0h exp=62", {ifa.x, ifa.y}); end
      bud = 400;
      while (!ifa.done && bud > 0) begin step(); bud--; end
      seq_ok = 1;
      foreach (qa[k]) if (qa[k] !== pt(k, 0)) seq_ok = 0;
      total += 2;
      if (qa.size() !== 256) begin bad++; $display("FAIL bp_count got=%0d exp=256", qa.size()); end
      if (seq_ok != 1) begin bad++; $display("FAIL bp_order got=out_of_order exp=raster_order"); end
   endtask

   task automatic test_gap();
      int seq_ok;
      clear();
      plot_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 22; i++) begin
         total++;
         if (ifb.plot_valid !== ((i % 3) == 0)) begin
            bad++; $display("FAIL gap_pattern i=%0d got=%0b exp=%0b", i, ifb.plot_valid, (i % 3) == 0);
         end
         step();
      end
      total += 2;
      if (ifb.done !== 1'b1) begin bad++; $display("FAIL gap_done got=%0b exp=1", ifb.done); end
      if (qb.size() !== 8) begin bad++; $display("FAIL gap_count got=%0d exp=8", qb.size()); end
      seq_ok = 1;
      foreach (qb[k]) if (qb[k] !== pt(k, 1)) seq_ok = 0;
      total++;
      if (seq_ok != 1) begin bad++; $display("FAIL gap_order got=out_of_order exp=raster_order"); end
      step();
   endtask

   task automatic test_abort();
      int bud;
      clear();
      plot_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      bud = 300;
      while (!(ifa.plot_valid && ifa.x == 4'd7 && ifa.y == 4'd9) && bud > 0) begin step(); bud--; end
      total++;
      if (bud == 0) begin bad++; $display("FAIL reach_7_9 got=timeout exp=point(7,9)"); end
      abort = 1'b1;
      step();
      abort = 1'b0;
      total += 3;
      if ({ifa.x, ifa.y, ifa.plot_valid, ifa.busy, ifa.done} !== 11'd0) begin
         bad++; $display("FAIL abort_state got=%0h exp=0", {ifa.x, ifa.y, ifa.plot_valid, ifa.busy, ifa.done});
      end
      if (qa.size() !== 151) begin bad++; $display("FAIL abort_count got=%0d exp=151", qa.size()); end
      if (qa.size() == 0 || qa[$] !== 8'h69) begin bad++; $display("FAIL abort_last got=%0d_pts exp=last_(6,9)", qa.size()); end
      abort = 1'b1; start = 1'b1;
      step();
      abort = 1'b0; start = 1'b0;
      total++;
      if ({ifa.plot_valid, ifa.busy} !== 2'b00) begin bad++; $display("FAIL abort_start got=%0b exp=0", {ifa.plot_valid, ifa.busy}); end
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      total++;
      if ({ifa.plot_valid, ifa.x, ifa.y} !== 9'h100) begin bad++; $display("FAIL restart got=%0h exp=100", {ifa.plot_valid, ifa.x, ifa.y}); end
   endtask

   task automatic test_start_ignored();
      int bud, seq_ok, seqb_ok;
      clear();
      plot_ready = 1'b1; start = 1'b1;
      step();
      bud = 3000;
      while (!ifa.done && bud > 0) begin
         start = 1'($urandom_range(0, 1));
         plot_ready = ($urandom_range(0, 3) != 0);
         step();
         bud--;
      end
      total++;
      if (bud == 0) begin bad++; $display("FAIL si_done got=timeout exp=done"); end
      seq_ok = 1; seqb_ok = 1;
      foreach (qa[k]) if (qa[k] !== pt(k, 0)) seq_ok = 0;
      foreach (qb[k]) if (qb[k] !== pt(k % 8, 1)) seqb_ok = 0;
      total += 3;
      if (qa.size() !== 256) begin bad++; $display("FAIL si_count got=%0d exp=256", qa.size()); end
      if (seq_ok != 1) begin bad++; $display("FAIL si_order got=out_of_order exp=raster_order"); end
      if (seqb_ok != 1) begin bad++; $display("FAIL si_order_b got=out_of_order exp=raster_order"); end
      start = 1'b1;
      step();
      total++;
      if ({ifa.plot_valid, ifa.busy} !== 2'b00) begin bad++; $display("FAIL start_in_done got=%0b exp=0", {ifa.plot_valid, ifa.busy}); end
      step();
      start = 1'b0;
      total++;
      if ({ifa.plot_valid, ifa.x, ifa.y} !== 9'h100) begin bad++; $display("FAIL start_after_done got=%0h exp=100", {ifa.plot_valid, ifa.x, ifa.y}); end
   endtask

   task automatic test_random();
      clear();
      for (int i = 0; i < 600; i++) begin
         start      = ($urandom_range(0, 3) == 0);
         abort      = ($urandom_range(0, 31) == 0);
         plot_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      abort = 1'b0; start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_scan();
      test_backpressure();
      test_gap();
      test_abort();
      test_start_ignored();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
